// File: rtl/axi_lite_pkg.sv
// Shared types and width helpers for the AXI4-Lite slave bridge.
//   resp_t      : AXI response codes
//   wr_state_t  : write-channel FSM states
//   rd_state_t  : read-channel FSM states
//   *_width()   : derived widths from DATA_W / NUM_WORDS
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int align_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_width(input int num_words);
        return $clog2(num_words);
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Byte address -> memory word index plus range flag.
//   addr     : AXI byte address
//   idx      : word index ((addr - BASE_ADDR) >> ALIGN)
//   in_range : addr >= BASE_ADDR and offset below NUM_WORDS*STRB_W
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_WORDS = 256,
    localparam int               ALIGN     = align_width(DATA_W),
    localparam int               IDX_W     = idx_width(NUM_WORDS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              in_range
);

    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_WORDS * strb_width(DATA_W));

    // One extra bit catches the borrow when addr is below BASE_ADDR; a borrowed
    // result is always >= 2**ADDR_W and therefore never below SPAN.
    logic [ADDR_W:0] diff;

    assign diff     = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign idx      = diff[ALIGN +: IDX_W];
    assign in_range = !diff[ADDR_W] && (diff < SPAN);

endmodule

// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite slave to native word-addressed memory port.
//   AW/W/B  : write channels, AW and W accepted independently
//   AR/R    : read channel, RD_LAT-cycle memory read latency
//   wr_*    : one-cycle memory write with byte strobes
//   rd_*    : one-cycle memory read strobe, rd_data returns RD_LAT later
//   err_cnt : saturating count of SLVERR handshakes
//
// Write FSM
//   state    | meaning
//   W_IDLE   | collecting AW and W, each held once accepted
//   W_COMMIT | one cycle: pulse wr_en if in range, latch error flag
//   W_RESP   | Bvalid high until Bready
// Read FSM
//   state    | meaning
//   R_IDLE   | ARready high, waiting for an address
//   R_WAIT   | rd_en issued, counting down the memory latency
//   R_RESP   | Rvalid high until Rready
module axi_lite_slave_bridge
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_WORDS = 256,
    parameter int                RD_LAT    = 1,
    localparam int               STRB_W    = strb_width(DATA_W),
    localparam int               IDX_W     = idx_width(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AWvalid,
    output logic              AWready,
    input  logic [ADDR_W-1:0] AWaddr,
    input  logic              Wvalid,
    output logic              Wready,
    input  logic [DATA_W-1:0] Wdata,
    input  logic [STRB_W-1:0] Wstrb,
    output logic              Bvalid,
    input  logic              Bready,
    output logic [1:0]        Bresp,
    input  logic              ARvalid,
    output logic              ARready,
    input  logic [ADDR_W-1:0] ARaddr,
    output logic              Rvalid,
    input  logic              Rready,
    output logic [DATA_W-1:0] Rdata,
    output logic [1:0]        Rresp,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [STRB_W-1:0] wr_strb,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [15:0]       err_cnt
);

    // Handshake/strobe outputs are qualified with !rst so that a reset raised
    // mid-transaction suppresses any pulse or response already in flight.
    logic live;
    assign live = !rst;

    // ---------------- write path ----------------
    wr_state_t         wr_state;
    logic              aw_held, aw_ok, w_held, wr_err;
    logic [IDX_W-1:0]  aw_idx;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [IDX_W-1:0]  aw_dec_idx;
    logic              aw_dec_ok;
    logic              aw_hs, w_hs, b_hs;

    axi_lite_addr_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .NUM_WORDS(NUM_WORDS)
    ) u_aw_decode (
        .addr(AWaddr), .idx(aw_dec_idx), .in_range(aw_dec_ok)
    );

    assign AWready = live && (wr_state == W_IDLE) && !aw_held;
    assign Wready  = live && (wr_state == W_IDLE) && !w_held;
    assign aw_hs   = AWvalid && AWready;
    assign w_hs    = Wvalid && Wready;
    assign Bvalid  = live && (wr_state == W_RESP);
    assign Bresp   = wr_err ? SLVERR : OKAY;
    assign b_hs    = Bvalid && Bready;
    assign wr_en   = live && (wr_state == W_COMMIT) && aw_ok;
    assign wr_addr = aw_idx;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            aw_ok    <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
            wr_err   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        aw_idx  <= aw_dec_idx;
                        aw_ok   <= aw_dec_ok;
                    end
                    if (w_hs) begin
                        w_held   <= 1'b1;
                        w_data_q <= Wdata;
                        w_strb_q <= Wstrb;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs))
                        wr_state <= W_COMMIT;
                end
                W_COMMIT: begin
                    wr_err   <= !aw_ok;
                    wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (Bready) begin
                        wr_state <= W_IDLE;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        wr_err   <= 1'b0;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rd_state_t         rd_state;
    logic [2:0]        lat_cnt;
    logic              rd_en_q, rd_fresh;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [DATA_W-1:0] rdata_q;
    resp_t             rresp_q;
    logic [IDX_W-1:0]  ar_dec_idx;
    logic              ar_dec_ok;
    logic              ar_hs, r_hs;

    axi_lite_addr_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .NUM_WORDS(NUM_WORDS)
    ) u_ar_decode (
        .addr(ARaddr), .idx(ar_dec_idx), .in_range(ar_dec_ok)
    );

    assign ARready = live && (rd_state == R_IDLE);
    assign ar_hs   = ARvalid && ARready;
    assign rd_en   = live && rd_en_q;
    assign rd_addr = rd_idx_q;
    assign Rvalid  = live && (rd_state == R_RESP);
    assign Rresp   = rresp_q;
    assign r_hs    = Rvalid && Rready;

    // Memory data becomes valid in the same cycle Rvalid rises, so the first
    // response cycle passes rd_data straight through; it is captured at that
    // edge and held from rdata_q for as long as Rready stays low.
    assign Rdata = rd_fresh ? rd_data : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            lat_cnt  <= '0;
            rd_en_q  <= 1'b0;
            rd_fresh <= 1'b0;
            rd_idx_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            rd_en_q <= 1'b0;
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        if (ar_dec_ok) begin
                            rd_en_q  <= 1'b1;
                            rd_idx_q <= ar_dec_idx;
                            lat_cnt  <= 3'(RD_LAT);
                            rresp_q  <= OKAY;
                            rd_state <= R_WAIT;
                        end else begin
                            rdata_q  <= '0;
                            rresp_q  <= SLVERR;
                            rd_state <= R_RESP;
                        end
                    end
                end
                R_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        rd_fresh <= 1'b1;
                        rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rd_fresh) begin
                        rdata_q  <= rd_data;
                        rd_fresh <= 1'b0;
                    end
                    if (Rready)
                        rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- error counter ----------------
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign err_inc = {1'b0, b_hs && wr_err} + {1'b0, r_hs && (rresp_q == SLVERR)};
    assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
module tb_axi_lite_slave_bridge;

    localparam int RD_LAT32 = 3;

    logic clk, rst;

    // 32-bit instance: BASE 0, 256 words, RD_LAT 3
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic        ARvalid, ARready, Rvalid, Rready, wr_en, rd_en;
    logic [31:0] AWaddr, ARaddr, Wdata, Rdata, wr_data, rd_data;
    logic [3:0]  Wstrb, wr_strb;
    logic [1:0]  Bresp, Rresp;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] err_cnt;

    // 64-bit instance: BASE 0x1000, 256 words, RD_LAT 1
    logic        aw_valid64, aw_ready64, w_valid64, w_ready64, b_valid64, b_ready64;
    logic        ar_valid64, ar_ready64, r_valid64, r_ready64, wr_en64, rd_en64;
    logic [31:0] aw_addr64, ar_addr64;
    logic [63:0] w_data64, r_data64, wr_data64, rd_data64;
    logic [7:0]  w_strb64, wr_strb64, wr_addr64, rd_addr64;
    logic [1:0]  b_resp64, r_resp64;
    logic [15:0] err_cnt64;

    axi_lite_slave_bridge #(.DATA_W(32), .BASE_ADDR(32'h0), .NUM_WORDS(256), .RD_LAT(RD_LAT32)) u_dut (
        .clk(clk), .rst(rst),
        .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
        .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
        .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
        .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .err_cnt(err_cnt)
    );

    axi_lite_slave_bridge #(.DATA_W(64), .BASE_ADDR(32'h1000), .NUM_WORDS(256), .RD_LAT(1)) u_dut64 (
        .clk(clk), .rst(rst),
        .AWvalid(aw_valid64), .AWready(aw_ready64), .AWaddr(aw_addr64),
        .Wvalid(w_valid64), .Wready(w_ready64), .Wdata(w_data64), .Wstrb(w_strb64),
        .Bvalid(b_valid64), .Bready(b_ready64), .Bresp(b_resp64),
        .ARvalid(ar_valid64), .ARready(ar_ready64), .ARaddr(ar_addr64),
        .Rvalid(r_valid64), .Rready(r_ready64), .Rdata(r_data64), .Rresp(r_resp64),
        .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_data(wr_data64), .wr_strb(wr_strb64),
        .rd_en(rd_en64), .rd_addr(rd_addr64), .rd_data(rd_data64), .err_cnt(err_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- memory model for the 32-bit instance ----------------
    logic [31:0] mem [256];
    logic [31:0] pipe [RD_LAT32];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            for (int i = 0; i < RD_LAT32; i++) pipe[i] <= 32'hBAD0BAD0;
        end else begin
            if (wr_en)
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            pipe[0] <= rd_en ? mem[rd_addr] : 32'hBAD0BAD0;
            for (int i = 1; i < RD_LAT32; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign rd_data = pipe[RD_LAT32-1];

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_exp_t;

    wr_exp_t     exp_wr_q[$];
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    logic [7:0]  exp_rd_q[$];

    wr_exp_t     mon_wr;
    logic [1:0]  mon_b;
    logic [33:0] mon_r;
    logic [7:0]  mon_idx;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: wr_en=1 idx=%0d, required no write", wr_addr);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    if ({wr_addr, wr_data, wr_strb} !== {mon_wr.idx, mon_wr.data, mon_wr.strb}) begin
                        errors++;
                        $display("FAIL wr_payload: got idx=%0d data=%h strb=%b, required idx=%0d data=%h strb=%b",
                                 wr_addr, wr_data, wr_strb, mon_wr.idx, mon_wr.data, mon_wr.strb);
                    end
                end
            end
            if (rd_en) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: rd_en=1 idx=%0d, required no read", rd_addr);
                end else begin
                    mon_idx = exp_rd_q.pop_front();
                    if (rd_addr !== mon_idx) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d, required %0d", rd_addr, mon_idx);
                    end
                end
            end
            if (Bvalid && Bready) begin
                checks++;
                if (exp_b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: Bresp=%b, required no response", Bresp);
                end else begin
                    mon_b = exp_b_q.pop_front();
                    if (Bresp !== mon_b) begin
                        errors++;
                        $display("FAIL bresp: got %b, required %b", Bresp, mon_b);
                    end
                end
            end
            if (Rvalid && Rready) begin
                checks++;
                if (exp_r_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected: Rresp=%b Rdata=%h, required no response", Rresp, Rdata);
                end else begin
                    mon_r = exp_r_q.pop_front();
                    if ({Rresp, Rdata} !== mon_r) begin
                        errors++;
                        $display("FAIL rdata: got resp=%b data=%h, required resp=%b data=%h",
                                 Rresp, Rdata, mon_r[33:32], mon_r[31:0]);
                    end
                end
            end
        end
    end

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name);
        int n = 0;
        while ((exp_wr_q.size() + exp_b_q.size() + exp_r_q.size() + exp_rd_q.size()) != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if ((exp_wr_q.size() + exp_b_q.size() + exp_r_q.size() + exp_rd_q.size()) != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d events outstanding, required 0", name,
                     exp_wr_q.size() + exp_b_q.size() + exp_r_q.size() + exp_rd_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({AWready, Wready, ARready, Bvalid, Rvalid, wr_en, rd_en} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {AWready, Wready, ARready, Bvalid, Rvalid, wr_en, rd_en});
        end
        checks++;
        if ({err_cnt, Rdata, Bresp, Rresp, wr_addr, wr_data, wr_strb, rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data: err_cnt=%h Rdata=%h Bresp=%b Rresp=%b wr_addr=%h wr_data=%h, required all 0",
                     err_cnt, Rdata, Bresp, Rresp, wr_addr, wr_data);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({AWready, Wready, ARready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 111", {AWready, Wready, ARready});
        end
    endtask

    task automatic test_same_cycle();
        @(posedge clk); #1;
        AWvalid = 1; AWaddr = 32'h10; Wvalid = 1; Wdata = 32'hDEADBEEF; Wstrb = 4'hF; Bready = 1;
        exp_wr_q.push_back('{idx: 8'd4, data: 32'hDEADBEEF, strb: 4'hF});
        exp_b_q.push_back(2'b00);
        @(negedge clk);
        checks++;
        if ({AWready, Wready} !== 2'b11) begin
            errors++;
            $display("FAIL same_cycle_ready: got %b, required 11", {AWready, Wready});
        end
        @(posedge clk); #1 AWvalid = 0; Wvalid = 0;
        @(negedge clk);
        checks++;
        if ({wr_en, Bvalid} !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_c1: wr_en,Bvalid=%b, required 10", {wr_en, Bvalid});
        end
        @(negedge clk);
        checks++;
        if ({wr_en, Bvalid} !== 2'b01) begin
            errors++;
            $display("FAIL same_cycle_c2: wr_en,Bvalid=%b, required 01", {wr_en, Bvalid});
        end
        drain("same_cycle");
    endtask

    task automatic test_w_before_aw();
        @(posedge clk); #1;
        Wvalid = 1; Wdata = 32'h11223344; Wstrb = 4'b0101; Bready = 1;
        @(posedge clk); #1 Wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, Wready, AWready} !== 3'b001) begin
                errors++;
                $display("FAIL w_first_wait%0d: wr_en,Wready,AWready=%b, required 001", i, {wr_en, Wready, AWready});
            end
        end
        @(posedge clk); #1;
        AWvalid = 1; AWaddr = 32'h20;
        exp_wr_q.push_back('{idx: 8'd8, data: 32'h11223344, strb: 4'b0101});
        exp_b_q.push_back(2'b00);
        @(posedge clk); #1 AWvalid = 0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL w_first_commit: wr_en=%b, required 1", wr_en);
        end
        drain("w_before_aw");
    endtask

    task automatic test_aw_before_w_zero_strb();
        @(posedge clk); #1;
        AWvalid = 1; AWaddr = 32'h3FC; Bready = 1;
        @(posedge clk); #1 AWvalid = 0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({wr_en, AWready, Wready} !== 3'b001) begin
                errors++;
                $display("FAIL aw_first_wait: wr_en,AWready,Wready=%b, required 001", {wr_en, AWready, Wready});
            end
        end
        @(posedge clk); #1;
        Wvalid = 1; Wdata = 32'hFFFFFFFF; Wstrb = 4'h0;
        exp_wr_q.push_back('{idx: 8'd255, data: 32'hFFFFFFFF, strb: 4'h0});
        exp_b_q.push_back(2'b00);
        @(posedge clk); #1 Wvalid = 0;
        drain("zero_strb");
    endtask

    task automatic test_read_latency();
        @(posedge clk); #1;
        ARvalid = 1; ARaddr = 32'h10; Rready = 0;
        exp_rd_q.push_back(8'd4);
        exp_r_q.push_back({2'b00, 32'hDEADBEEF});
        @(negedge clk);
        checks++;
        if (ARready !== 1'b1) begin
            errors++;
            $display("FAIL rd_arready: got %b, required 1", ARready);
        end
        @(posedge clk); #1 ARvalid = 0;
        @(negedge clk);
        checks++;
        if ({rd_en, Rvalid, ARready} !== 3'b100) begin
            errors++;
            $display("FAIL rd_c1: rd_en,Rvalid,ARready=%b, required 100", {rd_en, Rvalid, ARready});
        end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (Rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rd_early_c%0d: Rvalid=%b, required 0", c, Rvalid);
            end
        end
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if ({Rvalid, Rresp, Rdata} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL rd_hold_c%0d: Rvalid=%b Rresp=%b Rdata=%h, required 1 00 deadbeef", c, Rvalid, Rresp, Rdata);
            end
        end
        @(posedge clk); #1 Rready = 1;
        drain("read_latency");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h30, 32'h20, 32'h3FC};
        logic [31:0] exps  [3] = '{32'hA5A55A5A, 32'h00220044, 32'h00000000};
        logic [7:0]  idxs  [3] = '{8'd12, 8'd8, 8'd255};
        int n;
        @(posedge clk); #1;
        AWvalid = 1; AWaddr = 32'h30; Wvalid = 1; Wdata = 32'hA5A55A5A; Wstrb = 4'hF; Bready = 1; Rready = 1;
        exp_wr_q.push_back('{idx: 8'd12, data: 32'hA5A55A5A, strb: 4'hF});
        exp_b_q.push_back(2'b00);
        @(posedge clk); #1 AWvalid = 0; Wvalid = 0;
        n = 0;
        @(negedge clk);
        while (Bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            errors++;
            $display("FAIL b2b_bvalid_timeout: Bvalid=%b, required 1", Bvalid);
        end
        // Read issued right after the B handshake edge.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            ARvalid = 1; ARaddr = addrs[k];
            exp_rd_q.push_back(idxs[k]);
            exp_r_q.push_back({2'b00, exps[k]});
            n = 0;
            @(negedge clk);
            while (ARready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) begin
                errors++;
                $display("FAIL b2b_arready_timeout%0d: ARready=%b, required 1", k, ARready);
            end
        end
        @(posedge clk); #1 ARvalid = 0;
        drain("back_to_back");
    endtask

    task automatic test_out_of_range();
        @(posedge clk); #1;
        AWvalid = 1; AWaddr = 32'h400; Wvalid = 1; Wdata = 32'hCAFEF00D; Wstrb = 4'hF;
        ARvalid = 1; ARaddr = 32'h800; Bready = 1; Rready = 1;
        exp_b_q.push_back(2'b10);
        exp_r_q.push_back({2'b10, 32'h0});
        @(posedge clk); #1 AWvalid = 0; Wvalid = 0; ARvalid = 0;
        @(negedge clk);
        checks++;
        if ({wr_en, rd_en, Rvalid} !== 3'b001) begin
            errors++;
            $display("FAIL oor_c1: wr_en,rd_en,Rvalid=%b, required 001", {wr_en, rd_en, Rvalid});
        end
        @(negedge clk);
        checks++;
        if ({Bvalid, Bresp} !== 3'b110) begin
            errors++;
            $display("FAIL oor_c2: Bvalid,Bresp=%b, required 110", {Bvalid, Bresp});
        end
        drain("out_of_range");
        @(negedge clk);
        checks++;
        if (err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL err_cnt: got %0d, required 2", err_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        ARvalid = 1; ARaddr = 32'h10; Rready = 1;
        @(negedge clk);
        checks++;
        if (ARready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_arready: got %b, required 1", ARready);
        end
        @(posedge clk); #1 rst = 1; ARvalid = 0;
        @(negedge clk);
        checks++;
        if ({rd_en, Rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_c1: rd_en,Rvalid=%b, required 00", {rd_en, Rvalid});
        end
        @(negedge clk);
        checks++;
        if ({AWready, Wready, ARready, Bvalid, Rvalid, wr_en, rd_en, err_cnt, Rdata, Rresp} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b Rvalid=%b rd_en=%b err_cnt=%0d Rdata=%h, required all 0",
                     {AWready, Wready, ARready}, Rvalid, rd_en, err_cnt, Rdata);
        end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if (ARready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_release: ARready=%b, required 1", ARready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({rd_en, Rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_late%0d: rd_en,Rvalid=%b, required 00", i, {rd_en, Rvalid});
            end
        end
    endtask

    task automatic test_wide_64();
        @(posedge clk); #1;
        aw_valid64 = 1; aw_addr64 = 32'h1018; w_valid64 = 1;
        w_data64 = 64'h0123456789ABCDEF; w_strb64 = 8'hF0; b_ready64 = 1; r_ready64 = 1;
        @(posedge clk); #1 aw_valid64 = 0; w_valid64 = 0;
        @(negedge clk);
        checks++;
        if ({wr_en64, wr_addr64, wr_strb64, wr_data64} !== {1'b1, 8'd3, 8'hF0, 64'h0123456789ABCDEF}) begin
            errors++;
            $display("FAIL w64_commit: wr_en=%b idx=%0d strb=%h data=%h, required 1 3 f0 0123456789abcdef",
                     wr_en64, wr_addr64, wr_strb64, wr_data64);
        end
        @(negedge clk);
        checks++;
        if ({b_valid64, b_resp64} !== 3'b100) begin
            errors++;
            $display("FAIL w64_bresp_ok: Bvalid,Bresp=%b, required 100", {b_valid64, b_resp64});
        end
        @(posedge clk); #1;
        aw_valid64 = 1; aw_addr64 = 32'h0FF8; w_valid64 = 1; w_strb64 = 8'hFF;
        @(posedge clk); #1 aw_valid64 = 0; w_valid64 = 0;
        @(negedge clk);
        checks++;
        if (wr_en64 !== 1'b0) begin
            errors++;
            $display("FAIL w64_below_base: wr_en=%b, required 0", wr_en64);
        end
        @(negedge clk);
        checks++;
        if ({b_valid64, b_resp64} !== 3'b110) begin
            errors++;
            $display("FAIL w64_bresp_err: Bvalid,Bresp=%b, required 110", {b_valid64, b_resp64});
        end
        @(posedge clk); #1;
        ar_valid64 = 1; ar_addr64 = 32'h1800;
        @(posedge clk); #1 ar_valid64 = 0;
        @(negedge clk);
        checks++;
        if ({rd_en64, r_valid64, r_resp64, r_data64} !== {1'b0, 1'b1, 2'b10, 64'h0}) begin
            errors++;
            $display("FAIL r64_past_end: rd_en=%b Rvalid=%b Rresp=%b Rdata=%h, required 0 1 10 0",
                     rd_en64, r_valid64, r_resp64, r_data64);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_cnt64 !== 16'd2) begin
            errors++;
            $display("FAIL err_cnt64: got %0d, required 2", err_cnt64);
        end
    endtask

    initial begin
        rst = 1;
        AWvalid = 0; AWaddr = 0; Wvalid = 0; Wdata = 0; Wstrb = 0; Bready = 0;
        ARvalid = 0; ARaddr = 0; Rready = 0;
        aw_valid64 = 0; aw_addr64 = 0; w_valid64 = 0; w_data64 = 0; w_strb64 = 0; b_ready64 = 0;
        ar_valid64 = 0; ar_addr64 = 0; r_ready64 = 0; rd_data64 = 64'h0;

        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_aw_before_w_zero_strb();
        test_read_latency();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        test_wide_64();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
